// File: rtl/alu_control_if.sv
// Instruction, data-memory and ALU signals of the accumulator controller.
// The master view belongs to the controller; slave is the surrounding environment.
interface alu_control_if;
    logic        InstrValid;
    logic [11:0] Instr;
    logic        InstrReady;
    logic [7:0]  MemAddr;
    logic        MemRdReq;
    logic        MemRdValid;
    logic [7:0]  MemRdData;
    logic        MemWrReq;
    logic [7:0]  MemWrData;
    logic        MemWrAck;
    logic        AluEnable;
    logic [7:0]  AluOp1;
    logic [7:0]  AluOp2;
    logic [3:0]  AluMode;
    logic [3:0]  AluCflags;
    logic [7:0]  AluResult;
    logic [3:0]  AluFlags;
    logic [7:0]  Acc;
    logic [3:0]  FlagReg;
    logic        Busy;
    logic        Error;

    modport master (
        input  InstrValid, Instr, MemRdValid, MemRdData, MemWrAck, AluResult, AluFlags,
        output InstrReady, MemAddr, MemRdReq, MemWrReq, MemWrData, AluEnable,
               AluOp1, AluOp2, AluMode, AluCflags, Acc, FlagReg, Busy, Error
    );

    modport slave (
        output InstrValid, Instr, MemRdValid, MemRdData, MemWrAck, AluResult, AluFlags,
        input  InstrReady, MemAddr, MemRdReq, MemWrReq, MemWrData, AluEnable,
               AluOp1, AluOp2, AluMode, AluCflags, Acc, FlagReg, Busy, Error
    );
endinterface

// File: rtl/alu_control.sv
// Accumulator-style ALU sequencer: fetch operand from memory, run one ALU cycle,
// either update Acc or store the result back, with a bounded memory wait.
module alu_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic           Clk,
    input logic           Rst_n,
    alu_control_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [3:0]  MODE_STORE = 4'b0010;
    localparam logic [15:0] FLAG_MODES = 16'h8383;  // modes 0,1,7,8,9,15 update FlagReg
    localparam logic [7:0]  WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  mode_q;
    logic [7:0]  addr_q;
    logic [7:0]  opnd_q;
    logic [7:0]  wdata_q;
    logic [7:0]  acc_q;
    logic [3:0]  flag_q;
    logic [7:0]  wcnt_q;
    logic        err_q;
    logic        live_q;

    logic mem_wait, mem_done, mem_to, accept;

    always_comb begin
        mem_wait = (state_q == READ) || (state_q == WRITE);
        mem_done = ((state_q == READ) && bus.MemRdValid) || ((state_q == WRITE) && bus.MemWrAck);
        mem_to   = mem_wait && !mem_done && (wcnt_q == WAIT_LAST);
        accept   = (state_q == IDLE) && live_q && bus.InstrValid;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (bus.Instr[11:8] == MODE_STORE) ? EXEC : READ;
            READ:    if (mem_done || mem_to) state_d = mem_done ? EXEC : IDLE;
            EXEC:    state_d = (mode_q == MODE_STORE) ? WRITE : IDLE;
            WRITE:   if (mem_done || mem_to) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // live_q keeps InstrReady low while reset is asserted and until the first edge after it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mode_q  <= '0;
            addr_q  <= '0;
            opnd_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            flag_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            err_q  <= mem_to;
            if (accept) begin
                mode_q <= bus.Instr[11:8];
                addr_q <= bus.Instr[7:0];
            end
            if (!mem_wait)      wcnt_q <= '0;
            else if (!mem_done) wcnt_q <= wcnt_q + 8'd1;
            if ((state_q == READ) && bus.MemRdValid) opnd_q <= bus.MemRdData;
            if (state_q == EXEC) begin
                if (mode_q == MODE_STORE) wdata_q <= bus.AluResult;
                else                      acc_q   <= bus.AluResult;
                if (FLAG_MODES[mode_q])   flag_q  <= bus.AluFlags;
            end
        end
    end

    always_comb begin
        bus.InstrReady = (state_q == IDLE) && live_q;
        bus.MemAddr    = '0;
        bus.MemRdReq   = 1'b0;
        bus.MemWrReq   = 1'b0;
        bus.MemWrData  = '0;
        bus.AluEnable  = 1'b0;
        bus.AluOp1     = '0;
        bus.AluOp2     = '0;
        bus.AluMode    = '0;
        case (state_q)
            READ: begin
                bus.MemRdReq = 1'b1;
                bus.MemAddr  = addr_q;
            end
            EXEC: begin
                bus.AluEnable = 1'b1;
                bus.AluOp1    = acc_q;
                bus.AluOp2    = opnd_q;
                bus.AluMode   = mode_q;
            end
            WRITE: begin
                bus.MemWrReq  = 1'b1;
                bus.MemAddr   = addr_q;
                bus.MemWrData = wdata_q;
            end
            default: ;
        endcase
        bus.AluCflags = flag_q;
        bus.Acc       = acc_q;
        bus.FlagReg   = flag_q;
        bus.Busy      = (state_q != IDLE);
        bus.Error     = err_q;
    end
endmodule

// File: tb/tb_alu_control.sv
// Randomised bench for alu_control: a toy ALU and memory responder around the DUT,
// and a per-instruction transaction model for Acc/FlagReg/operand/store data.
module tb_alu_control;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] m_acc, m_opnd;
    logic [3:0] m_flg;

    alu_control_if bus();

    alu_control #(.MEM_TIMEOUT(TO)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_r(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
        case (m)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a;
            4'd3:    return b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a + b + 8'd1;
            4'd8:    return b - a;
            4'd9:    return {a[6:0], a[7]};
            default: return (a ^ {b[3:0], b[7:4]}) + {4'd0, m};
        endcase
    endfunction

    function automatic logic [3:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
        logic [7:0] r;
        logic [8:0] s;
        r = alu_r(a, b, m);
        s = {1'b0, a} + {1'b0, b};
        return {r == 8'd0, r[7], s[8], ^r};
    endfunction

    function automatic bit sets_flags(input logic [3:0] m);
        return m inside {4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd15};
    endfunction

    assign bus.AluResult = alu_r(bus.AluOp1, bus.AluOp2, bus.AluMode);
    assign bus.AluFlags  = alu_f(bus.AluOp1, bus.AluOp2, bus.AluMode);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serve one memory request, answering in request cycle dly (never if dly >= TO).
    task automatic mem_wait(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                            input logic [7:0] rd, input int dly, output int cyc, output int bad);
        cyc = 0;
        bad = 0;
        while ((wr ? bus.MemWrReq : bus.MemRdReq) && cyc < 300) begin
            if (bus.MemAddr !== a || bus.InstrReady !== 1'b0 || bus.AluEnable !== 1'b0 ||
                (wr ? bus.MemRdReq : bus.MemWrReq) !== 1'b0 || (wr && bus.MemWrData !== wd))
                bad++;
            if (wr) begin
                bus.MemWrAck   = (cyc == dly);
                bus.MemRdValid = 1'($urandom_range(0, 1));
                bus.MemRdData  = 8'($urandom);
            end else begin
                bus.MemRdValid = (cyc == dly);
                bus.MemRdData  = rd;
                bus.MemWrAck   = 1'($urandom_range(0, 1));
            end
            cyc++;
            @(negedge clk);
        end
        bus.MemWrAck   = 1'b0;
        bus.MemRdValid = 1'b0;
    endtask

    task automatic do_instr(input logic [11:0] ins, input logic [7:0] rd, input int dly, input bit hold);
        logic [3:0] m;
        logic [7:0] a, res, e_wd;
        bit st, to;
        int cyc, bad, g;
        m    = ins[11:8];
        a    = ins[7:0];
        st   = (m == 4'd2);
        to   = (dly >= TO);
        e_wd = '0;
        g    = 0;
        @(negedge clk);
        while (!bus.InstrReady && g < 50) begin g++; @(negedge clk); end
        chk("ready", bus.InstrReady, 1);
        bus.InstrValid = 1'b1;
        bus.Instr      = ins;
        @(negedge clk);
        if (hold) bus.Instr = ins ^ 12'hFFF;
        else      bus.InstrValid = 1'b0;
        if (!st) begin
            mem_wait(1'b0, a, 8'd0, rd, dly, cyc, bad);
            chk("rd_cycles", cyc, to ? TO : dly + 1);
            chk("rd_stable", bad, 0);
            if (!to) m_opnd = rd;
        end
        if (st || !to) begin
            chk("alu_en", bus.AluEnable, 1);
            chk("alu_op1", bus.AluOp1, m_acc);
            chk("alu_op2", bus.AluOp2, m_opnd);
            chk("alu_mode", bus.AluMode, m);
            chk("alu_cflags", bus.AluCflags, m_flg);
            chk("exec_busy", bus.Busy, 1);
            res = alu_r(m_acc, m_opnd, m);
            if (sets_flags(m)) m_flg = alu_f(m_acc, m_opnd, m);
            if (st) e_wd = res;
            else    m_acc = res;
            @(negedge clk);
            if (st) begin
                mem_wait(1'b1, a, e_wd, 8'd0, dly, cyc, bad);
                chk("wr_cycles", cyc, to ? TO : dly + 1);
                chk("wr_stable", bad, 0);
            end
        end
        chk("error", bus.Error, to);
        chk("idle_busy", bus.Busy, 0);
        chk("idle_ready", bus.InstrReady, 1);
        chk("idle_memaddr", bus.MemAddr, 0);
        chk("acc", bus.Acc, m_acc);
        chk("flagreg", bus.FlagReg, m_flg);
        bus.InstrValid = 1'b0;
        if (to) begin
            @(negedge clk);
            chk("error_pulse", bus.Error, 0);
        end
    endtask

    initial begin
        int dly;
        bus.InstrValid = 1'b0;
        bus.Instr      = '0;
        bus.MemRdValid = 1'b0;
        bus.MemRdData  = '0;
        bus.MemWrAck   = 1'b0;
        m_acc  = '0;
        m_flg  = '0;
        m_opnd = '0;

        #2;
        chk("rst_ready", bus.InstrReady, 0);
        chk("rst_acc", bus.Acc, 0);
        chk("rst_flag", bus.FlagReg, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_req", {bus.MemRdReq, bus.MemWrReq, bus.AluEnable, bus.Error}, 0);
        chk("rst_addr", bus.MemAddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", bus.InstrReady, 0);
        @(negedge clk);
        chk("ready_after_edge", bus.InstrReady, 1);

        do_instr(12'h305, 8'h7F, 0, 1'b0);
        chk("load_acc", bus.Acc, 8'h7F);
        chk("load_flag", bus.FlagReg, 0);
        do_instr(12'h010, 8'h01, 0, 1'b0);
        chk("add_acc", bus.Acc, 8'h80);
        do_instr(12'h3A0, 8'hA5, 1, 1'b0);
        do_instr(12'h23C, 8'h00, 2, 1'b0);
        chk("store_acc", bus.Acc, 8'hA5);
        do_instr(12'h110, 8'h33, TO, 1'b0);
        do_instr(12'h122, 8'h44, TO - 1, 1'b0);
        do_instr(12'h250, 8'h00, TO, 1'b0);
        do_instr(12'h701, 8'h0F, 3, 1'b1);
        do_instr(12'h2C3, 8'h00, 0, 1'b1);

        // Reset while a store waits for its ack.
        @(negedge clk);
        bus.InstrValid = 1'b1;
        bus.Instr      = 12'h240;
        @(negedge clk);
        bus.InstrValid = 1'b0;
        @(negedge clk);
        chk("wr_pending", bus.MemWrReq, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_wrreq", bus.MemWrReq, 0);
        chk("rstw_acc", bus.Acc, 0);
        chk("rstw_busy", bus.Busy, 0);
        chk("rstw_ready", bus.InstrReady, 0);
        m_acc  = '0;
        m_flg  = '0;
        m_opnd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_ready_after", bus.InstrReady, 1);
        do_instr(12'h0AA, 8'h5A, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            dly = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
            do_instr(12'($urandom), 8'($urandom), dly, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, 16, cycles a memory request may wait for MemRdValid/MemWrAck before abort (range 2..255).
REQ-002 Ports:
- Clk  in  1  sole clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- InstrValid  in  1  instruction offered.
- Instr  in  12  [11:8]=ALU mode, [7:0]=memory address.
- InstrReady  out  1  block can accept an instruction.
- MemAddr  out  8  data-memory address.
- MemRdReq  out  1  read request, level.
- MemRdValid  in  1  read data valid.
- MemRdData  in  8  read data.
- MemWrReq  out  1  write request, level.
- MemWrData  out  8  write data.
- MemWrAck  in  1  write accepted.
- AluEnable  out  1  ALU enable.
- AluOp1  out  8  ALU Operand1.
- AluOp2  out  8  ALU Operand2.
- AluMode  out  4  ALU Mode.
- AluCflags  out  4  ALU current flags.
- AluResult  in  8  ALU result.
- AluFlags  in  4  ALU flags.
- Acc  out  8  accumulator.
- FlagReg  out  4  flag register.
- Busy  out  1  state != IDLE.
- Error  out  1  one-cycle pulse on memory timeout.
REQ-003 One clock; reset is asynchronous and active-low.

Function
REQ-004 FSM states: IDLE, READ, EXEC, WRITE; one transition per Clk edge at most.
REQ-005 IDLE: InstrReady=1; on InstrValid&&InstrReady latch Instr into mode/address registers; mode 4'b0010 -> EXEC, all other modes -> READ.
REQ-006 READ: MemRdReq=1, MemAddr=latched address, held stable until MemRdValid; on MemRdValid capture MemRdData into operand register -> EXEC.
REQ-007 EXEC lasts exactly one cycle: AluEnable=1, AluOp1=Acc, AluOp2=operand register, AluMode=latched mode, AluCflags=FlagReg.
REQ-008 EXEC exit, mode 4'b0010: capture AluResult into write register -> WRITE; Acc, FlagReg unchanged.
REQ-009 EXEC exit, other modes: Acc<=AluResult -> IDLE.
REQ-010 EXEC exit: FlagReg<=AluFlags only for modes 0000, 0001, 0111, 1000, 1001, 1111; otherwise FlagReg unchanged.
REQ-011 WRITE: MemWrReq=1, MemAddr=latched address, MemWrData=write register, held stable until MemWrAck -> IDLE.
REQ-012 Outside EXEC: AluEnable=0, AluOp1/AluOp2/AluMode=0; AluCflags=FlagReg always.
REQ-013 MemRdReq/MemWrReq=0 outside READ/WRITE; MemAddr=0 in IDLE.
REQ-014 Timeout: 8-bit wait counter cleared on entry to READ/WRITE, +1 each cycle without valid/ack; at count MEM_TIMEOUT-1 without valid/ack: Error=1 for that next cycle, -> IDLE, Acc/FlagReg/memory untouched.
REQ-015 Valid/ack in the same cycle the counter reaches MEM_TIMEOUT-1 takes priority; no Error.
REQ-016 MemRdValid/MemWrAck outside READ/WRITE are ignored.
REQ-017 InstrValid outside IDLE is ignored; InstrReady=0 in READ/EXEC/WRITE.
REQ-018 Latency with zero-wait memory: accept at edge N, READ cycle N..N+1, EXEC N+1..N+2, Acc updated at edge N+2, InstrReady=1 in cycle after edge N+2; mode 0010 with immediate ack: MemWrReq for one cycle, IDLE after 2 edges.

Reset
REQ-019 Rst_n low: immediately state=IDLE, Acc=0, FlagReg=0, all internal registers 0, every output 0, InstrReady=0.
REQ-020 Reset mid-READ/WRITE aborts the transaction; requests drop asynchronously; no partial Acc/FlagReg update.
REQ-021 After Rst_n rises, InstrReady=1 from the first Clk edge.

Verification
REQ-022 Reset, Acc=0; Instr=12'h305 (move mem->acc, addr 05), MemRdData=8'h7F zero-wait -> MemAddr=05, Acc=8'h7F, FlagReg=0.
REQ-023 Acc=8'h7F; Instr=12'h010 (add), MemRdData=8'h01 -> AluOp1=7F, AluOp2=01, Acc=8'h80, FlagReg=AluFlags from that EXEC cycle.
REQ-024 Acc=8'hA5; Instr=12'h2_3C (0010), MemWrAck after 3 cycles -> no MemRdReq, MemWrReq high 3 cycles with MemAddr=3C, MemWrData=A5; Acc unchanged.
REQ-025 MEM_TIMEOUT=16; Instr=12'h110, MemRdValid never -> MemRdReq high 16 cycles, Error pulse 1 cycle, IDLE, Acc/FlagReg unchanged.
REQ-026 Rst_n low during WRITE wait -> MemWrReq=0 immediately, Acc=0, Busy=0; next instruction accepted normally.
REQ-027 InstrValid held high through a whole instruction -> exactly one instruction accepted per IDLE visit.
